// File: rtl/command_frame_rx_if.sv
// Byte stream from the UART receiver core into the command frame decoder.
interface command_frame_rx_if;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;

    modport master (output uart_rx_data, output uart_rx_valid);
    modport slave  (input  uart_rx_data, input  uart_rx_valid);
endinterface

// File: rtl/command_frame_rx.sv
// Decodes 5-byte host command frames (HEADER, CMD, D_HI, D_LO, CHK) into the
// motor-control register set, with an inter-byte timeout that aborts partial frames.
module command_frame_rx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned TIMEOUT_MS = 5,
    parameter logic [7:0]  HEADER     = 8'hAA,
    parameter logic [15:0] KP_RST     = 16'd256,
    parameter logic [15:0] KI_RST     = 16'd0,
    parameter logic [15:0] KD_RST     = 16'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    command_frame_rx_if.slave        uart,
    output logic signed [15:0]       target0,
    output logic signed [15:0]       target1,
    output logic [15:0]              kp,
    output logic [15:0]              ki,
    output logic [15:0]              kd,
    output logic                     transmit_enable,
    output logic                     cmd_ok,
    output logic                     cmd_err,
    output logic [7:0]               last_cmd
);
    localparam longint TO_CYC = longint'(TIMEOUT_MS) * longint'(CLK_FREQ) / 1000;
    localparam int     CW     = $clog2(TO_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

    typedef enum logic [2:0] {IDLE, GET_CMD, GET_HI, GET_LO, GET_CHK} state_t;

    state_t        state;
    logic [7:0]    sum;
    logic [7:0]    cmd;
    logic [7:0]    d_hi;
    logic [7:0]    d_lo;
    logic [CW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            sum             <= '0;
            cmd             <= '0;
            d_hi            <= '0;
            d_lo            <= '0;
            to_cnt          <= '0;
            target0         <= '0;
            target1         <= '0;
            kp              <= KP_RST;
            ki              <= KI_RST;
            kd              <= KD_RST;
            transmit_enable <= 1'b0;
            cmd_ok          <= 1'b0;
            cmd_err         <= 1'b0;
            last_cmd        <= '0;
        end else begin
            cmd_ok  <= 1'b0;
            cmd_err <= 1'b0;
            // An arriving byte always beats a timeout expiring on the same edge.
            if (uart.uart_rx_valid) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (uart.uart_rx_data == HEADER) begin
                            state <= GET_CMD;
                            sum   <= '0;
                        end
                    end
                    GET_CMD: begin
                        cmd   <= uart.uart_rx_data;
                        sum   <= uart.uart_rx_data;
                        state <= GET_HI;
                    end
                    GET_HI: begin
                        d_hi  <= uart.uart_rx_data;
                        sum   <= sum + uart.uart_rx_data;
                        state <= GET_LO;
                    end
                    GET_LO: begin
                        d_lo  <= uart.uart_rx_data;
                        sum   <= sum + uart.uart_rx_data;
                        state <= GET_CHK;
                    end
                    GET_CHK: begin
                        state <= IDLE;
                        if (uart.uart_rx_data != sum) begin
                            cmd_err <= 1'b1;
                        end else begin
                            cmd_ok   <= 1'b1;
                            last_cmd <= cmd;
                            case (cmd)
                                8'h01: target0 <= {d_hi, d_lo};
                                8'h02: target1 <= {d_hi, d_lo};
                                8'h03: kp <= {d_hi, d_lo};
                                8'h04: ki <= {d_hi, d_lo};
                                8'h05: kd <= {d_hi, d_lo};
                                8'h06: transmit_enable <= d_lo[0];
                                8'h07: begin
                                    target0 <= '0;
                                    target1 <= '0;
                                end
                                default: begin
                                    cmd_ok   <= 1'b0;
                                    cmd_err  <= 1'b1;
                                    last_cmd <= last_cmd;
                                end
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == TO_LAST) begin
                    state   <= IDLE;
                    cmd_err <= 1'b1;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_command_frame_rx.sv
// Directed and randomized frame stimulus against a frame-level reference model.
module tb_command_frame_rx;
    localparam int unsigned CLK_FREQ   = 100_000;
    localparam int unsigned TIMEOUT_MS = 5;
    localparam int TO_CYC = TIMEOUT_MS * CLK_FREQ / 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    command_frame_rx_if bus ();

    logic signed [15:0] target0, target1;
    logic [15:0] kp, ki, kd;
    logic transmit_enable, cmd_ok, cmd_err;
    logic [7:0] last_cmd;

    command_frame_rx #(
        .CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS), .HEADER(8'hAA),
        .KP_RST(16'd256), .KI_RST(16'd0), .KD_RST(16'd0)
    ) dut (
        .clk(clk), .rst(rst), .uart(bus.slave),
        .target0(target0), .target1(target1),
        .kp(kp), .ki(ki), .kd(kd),
        .transmit_enable(transmit_enable),
        .cmd_ok(cmd_ok), .cmd_err(cmd_err), .last_cmd(last_cmd)
    );

    int cmps = 0;
    int errs = 0;

    logic signed [15:0] m_t0, m_t1;
    logic [15:0] m_kp, m_ki, m_kd;
    logic m_te, exp_ok, exp_err;
    logic [7:0] m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".target0"}, 32'(target0), 32'(m_t0));
        check({tag, ".target1"}, 32'(target1), 32'(m_t1));
        check({tag, ".kp"}, 32'(kp), 32'(m_kp));
        check({tag, ".ki"}, 32'(ki), 32'(m_ki));
        check({tag, ".kd"}, 32'(kd), 32'(m_kd));
        check({tag, ".transmit_enable"}, 32'(transmit_enable), 32'(m_te));
        check({tag, ".last_cmd"}, 32'(last_cmd), 32'(m_last));
        check({tag, ".cmd_ok"}, 32'(cmd_ok), 32'(exp_ok));
        check({tag, ".cmd_err"}, 32'(cmd_err), 32'(exp_err));
    endtask

    task automatic model_reset();
        m_t0 = '0; m_t1 = '0;
        m_kp = 16'd256; m_ki = '0; m_kd = '0;
        m_te = 1'b0; m_last = '0;
        exp_ok = 1'b0; exp_err = 1'b0;
    endtask

    // Frame-level reference: what a whole frame does to the register set.
    task automatic model_frame(input logic [7:0] c, input logic [15:0] d, input logic [7:0] chk);
        int s;
        s = (int'(c) + int'(d[15:8]) + int'(d[7:0])) % 256;
        exp_ok = 1'b0;
        exp_err = 1'b0;
        if (int'(chk) != s) exp_err = 1'b1;
        else begin
            exp_ok = 1'b1;
            case (c)
                8'h01: m_t0 = d;
                8'h02: m_t1 = d;
                8'h03: m_kp = d;
                8'h04: m_ki = d;
                8'h05: m_kd = d;
                8'h06: m_te = d[0];
                8'h07: begin m_t0 = '0; m_t1 = '0; end
                default: begin exp_ok = 1'b0; exp_err = 1'b1; end
            endcase
            if (exp_ok) m_last = c;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.uart_rx_data = b;
        bus.uart_rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.uart_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input logic [7:0] c, input logic [15:0] d, input logic [7:0] chk, input string tag);
        send(8'hAA); send(c); send(d[15:8]); send(d[7:0]); send(chk);
        model_frame(c, d, chk);
        check_all(tag);
    endtask

    task automatic quiet(input string tag);
        idle(1);
        exp_ok = 1'b0; exp_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int n;
        logic [7:0] c, chk;
        logic [15:0] d;
        bus.uart_rx_data = '0;
        bus.uart_rx_valid = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        model_reset();
        check_all("reset");

        frame(8'h01, 16'h03E8, 8'hEC, "t0_1000");
        quiet("t0_pulse_width");
        frame(8'h02, 16'hFC18, 8'h16, "t1_neg1000");
        frame(8'h06, 16'h0001, 8'h07, "te_on");
        quiet("te_after");
        frame(8'h03, 16'h0200, 8'h00, "bad_chk");
        frame(8'h04, 16'h0123, 8'h28, "after_bad");
        frame(8'h09, 16'h0000, 8'h09, "unknown_cmd");
        quiet("unknown_after");

        // Timeout: measure idle cycles until the abort pulse.
        send(8'hAA); send(8'h01);
        n = 0;
        while (!cmd_err && n < 3 * TO_CYC) begin @(posedge clk); #1; n++; end
        check("timeout_cycles", 32'(n), 32'(TO_CYC));
        exp_ok = 1'b0; exp_err = 1'b1;
        check_all("timeout_pulse");
        quiet("timeout_after");
        idle(TO_CYC);
        frame(8'h05, 16'h0042, 8'h47, "after_timeout");

        // A byte landing on the expiry edge beats the timeout.
        send(8'hAA);
        idle(TO_CYC - 1);
        send(8'h01);
        check("expiry_byte_wins.cmd_err", 32'(cmd_err), 32'd0);
        send(8'h12); send(8'h34); send(8'h47);
        model_frame(8'h01, 16'h1234, 8'h47);
        check_all("expiry_byte_wins.frame");

        send(8'h00);
        frame(8'h01, 16'hAA00, 8'hAB, "aa_payload");
        frame(8'h07, 16'h0000, 8'h07, "estop");

        frame(8'h03, 16'h0333, 8'h39, "kp_before_rst");
        send(8'hAA); send(8'h01); send(8'h03);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        model_reset();
        check_all("mid_frame_rst");
        send(8'hE8); send(8'hEC);
        check_all("rst_left_idle");
        frame(8'h01, 16'h03E8, 8'hEC, "after_rst");

        // Randomized frames with garbage and gaps between them.
        for (int i = 0; i < 150; i++) begin
            c = 8'($urandom_range(0, 9));
            d = 16'($urandom);
            chk = c + d[15:8] + d[7:0];
            if ($urandom_range(0, 4) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            frame(c, d, chk, "rand");
            n = $urandom_range(0, 3);
            for (int g = 0; g < n; g++) begin
                logic [7:0] gb;
                gb = 8'($urandom);
                if (gb == 8'hAA) gb = 8'h55;
                if (g == 0) quiet("rand_gap");
                else if ($urandom_range(0, 1) == 1) send(gb);
                else idle(1);
            end
        end
        exp_ok = 1'b0; exp_err = 1'b0;
        idle(1);
        check_all("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
